// File: rtl/awgn_pkg.sv
// Shared constants and types for the AWGN generator blocks.
// Includes ROM geometry, channel-state encoding and the in-flight read tag.
package awgn_pkg;

    localparam int unsigned AWGN_ADDR_W = 6;
    localparam int unsigned AWGN_C0_W   = 20;
    localparam int unsigned AWGN_C1_W   = 12;

    // Tag id is sized for the largest supported channel count.
    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned ID_W    = $clog2(MAX_REQ);

    typedef logic [1:0] ch_state_t;

    localparam ch_state_t StIdle = 2'd0;
    localparam ch_state_t StPend = 2'd1;
    localparam ch_state_t StFull = 2'd2;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first eligible index at or after ptr, wrapping.
// Produces a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_vld && eligible[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sqrt_coeff_arbiter.sv
// Shares the sqrt-coefficient ROM between NUM_REQ requesters: round-robin grant,
// two-stage tag pipeline matching ROM latency, one-entry response buffer per channel.
module sqrt_coeff_arbiter
    import awgn_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = AWGN_ADDR_W,
    parameter int unsigned C0_W    = AWGN_C0_W,
    parameter int unsigned C1_W    = AWGN_C1_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [C0_W-1:0]           rom_c0,
    input  logic [C1_W-1:0]           rom_c1,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ*C0_W-1:0]   rsp_c0,
    output logic [NUM_REQ*C1_W-1:0]   rsp_c1,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ch_active;
    logic [IW-1:0]      grant_idx;
    logic               grant_vld;
    logic [IW-1:0]      rr_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    tag_t               s1_q;
    tag_t               s2_q;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (rr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign req_ready = grant;
    assign rom_addr  = rom_addr_q;
    assign busy      = (|ch_active) | s1_q.vld | s2_q.vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            rom_addr_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            if (grant_vld) begin
                rom_addr_q <= addr_arr[grant_idx];
                rr_q       <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
            end
            s1_q.vld <= grant_vld;
            s1_q.id  <= ID_W'(grant_idx);
            // s2 lines up with the cycle in which the ROM output reflects s1's address.
            s2_q     <= s1_q;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
        ch_state_t       state_q;
        ch_state_t       state_d;
        logic [C0_W-1:0] c0_q;
        logic [C1_W-1:0] c1_q;
        logic            cap;
        logic            pop;

        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign cap         = s2_q.vld && (s2_q.id == ID_W'(i));
        assign pop         = (state_q == StFull) && rsp_ready[i];
        // Reset gating keeps req_ready low during the reset cycle itself.
        assign eligible[i] = req_valid[i] && (state_q == StIdle) && !rst;
        assign ch_active[i] = (state_q != StIdle);
        assign rsp_valid[i] = (state_q == StFull);
        assign rsp_c0[i*C0_W +: C0_W] = c0_q;
        assign rsp_c1[i*C1_W +: C1_W] = c1_q;

        always_comb begin
            state_d = state_q;
            case (state_q)
                StIdle:  if (grant[i]) state_d = StPend;
                StPend:  if (cap)      state_d = StFull;
                StFull:  if (pop)      state_d = StIdle;
                default:               state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StIdle;
                c0_q    <= '0;
                c1_q    <= '0;
            end else begin
                state_q <= state_d;
                if (cap) begin
                    c0_q <= rom_c0;
                    c1_q <= rom_c1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sqrt_coeff_arbiter.sv
// Directed bench: cycle table on a 2-channel instance plus hand sequences for
// mid-flight reset and 3-channel round-robin wrap-around.
module tb_sqrt_coeff_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 2-channel instance
    logic [1:0]  req_valid2, req_ready2, rsp_valid2, rsp_ready2;
    logic [5:0]  a0_2, a1_2, rom_addr2;
    logic [11:0] req_addr2;
    logic [19:0] rom_c0_2;
    logic [11:0] rom_c1_2;
    logic [39:0] rsp_c0_2;
    logic [23:0] rsp_c1_2;
    logic        busy2;

    assign req_addr2 = {a1_2, a0_2};

    sqrt_coeff_arbiter #(
        .NUM_REQ (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid2),
        .req_ready (req_ready2),
        .req_addr  (req_addr2),
        .rom_addr  (rom_addr2),
        .rom_c0    (rom_c0_2),
        .rom_c1    (rom_c1_2),
        .rsp_valid (rsp_valid2),
        .rsp_ready (rsp_ready2),
        .rsp_c0    (rsp_c0_2),
        .rsp_c1    (rsp_c1_2),
        .busy      (busy2)
    );

    // 3-channel instance
    logic [2:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [17:0] req_addr3;
    logic [5:0]  rom_addr3;
    logic [19:0] rom_c0_3;
    logic [11:0] rom_c1_3;
    logic [59:0] rsp_c0_3;
    logic [35:0] rsp_c1_3;
    logic        busy3;

    sqrt_coeff_arbiter #(
        .NUM_REQ (3)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_addr  (req_addr3),
        .rom_addr  (rom_addr3),
        .rom_c0    (rom_c0_3),
        .rom_c1    (rom_c1_3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
        .rsp_c0    (rsp_c0_3),
        .rsp_c1    (rsp_c1_3),
        .busy      (busy3)
    );

    // ROM models: 1-cycle registered lookup.
    always @(posedge clk) begin
        rom_c0_2 <= 20'h10000 + 20'(rom_addr2);
        rom_c1_2 <= 12'h800 + 12'(rom_addr2);
        rom_c0_3 <= 20'h10000 + 20'(rom_addr3);
        rom_c1_3 <= 12'h800 + 12'(rom_addr3);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic [5:0] a0;
        logic [1:0] rdy_in;
        logic [1:0] ready;
        logic [5:0] rom;
        logic [1:0] rspv;
        logic       busy;
        logic [5:0] d0;
        logic [5:0] d1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] rv, input logic [5:0] a0,
                       input logic [1:0] rdy_in, input logic [1:0] ready,
                       input logic [5:0] rom, input logic [1:0] rspv, input logic bsy,
                       input logic [5:0] d0);
        vec_t v;
        v.rst = r; v.rv = rv; v.a0 = a0; v.rdy_in = rdy_in; v.ready = ready;
        v.rom = rom; v.rspv = rspv; v.busy = bsy; v.d0 = d0; v.d1 = 6'd40;
        tbl.push_back(v);
    endtask

    int cnt [3];
    int exp_next;
    int gidx;
    int lat;
    bit found;

    initial begin
        // Single request, then reset, contention, and ch1 backpressure.
        add(0, 2'b01, 5, 2'b11, 2'b01,  0, 2'b00, 0, 5);   // c0 accept ch0
        add(0, 2'b00, 5, 2'b11, 2'b00,  5, 2'b00, 1, 5);
        add(0, 2'b00, 5, 2'b11, 2'b00,  5, 2'b00, 1, 5);
        add(0, 2'b00, 5, 2'b11, 2'b00,  5, 2'b01, 1, 5);   // c3 response
        add(0, 2'b00, 5, 2'b11, 2'b00,  5, 2'b00, 0, 5);
        add(1, 2'b11, 3, 2'b11, 2'b00,  5, 2'b00, 0, 3);   // c5 reset cycle
        add(0, 2'b11, 3, 2'b11, 2'b01,  0, 2'b00, 0, 3);
        add(0, 2'b11, 3, 2'b11, 2'b10,  3, 2'b00, 1, 3);
        add(0, 2'b11, 3, 2'b11, 2'b00, 40, 2'b00, 1, 3);
        add(0, 2'b11, 3, 2'b11, 2'b00, 40, 2'b01, 1, 3);
        add(0, 2'b11, 3, 2'b11, 2'b01, 40, 2'b10, 1, 3);   // c10 ch0 re-granted
        add(0, 2'b11, 3, 2'b11, 2'b10,  3, 2'b00, 1, 3);
        add(0, 2'b11, 3, 2'b01, 2'b00, 40, 2'b00, 1, 3);
        add(0, 2'b11, 3, 2'b01, 2'b00, 40, 2'b01, 1, 3);
        add(0, 2'b11, 3, 2'b01, 2'b01, 40, 2'b10, 1, 3);   // c14 ch1 FULL, held
        for (int k = 0; k < 2; k++) begin
            add(0, 2'b11, 3, 2'b01, 2'b00, 3, 2'b10, 1, 3);
            add(0, 2'b11, 3, 2'b01, 2'b00, 3, 2'b10, 1, 3);
            add(0, 2'b11, 3, 2'b01, 2'b00, 3, 2'b11, 1, 3);
            add(0, 2'b11, 3, 2'b01, 2'b01, 3, 2'b10, 1, 3);
        end
        add(0, 2'b11, 3, 2'b01, 2'b00,  3, 2'b10, 1, 3);   // c23
        add(0, 2'b11, 3, 2'b11, 2'b00,  3, 2'b10, 1, 3);   // c24 ch1 popped
        add(0, 2'b11, 3, 2'b11, 2'b10,  3, 2'b01, 1, 3);
        add(0, 2'b11, 3, 2'b11, 2'b01, 40, 2'b00, 1, 3);
        add(0, 2'b00, 3, 2'b11, 2'b00,  3, 2'b00, 1, 3);
        add(0, 2'b00, 3, 2'b11, 2'b00,  3, 2'b10, 1, 3);
        add(0, 2'b00, 3, 2'b11, 2'b00,  3, 2'b01, 1, 3);
        add(0, 2'b00, 3, 2'b11, 2'b00,  3, 2'b00, 0, 3);   // c30

        rst = 1'b1;
        req_valid2 = '0; rsp_ready2 = '0; a0_2 = '0; a1_2 = 6'd40;
        req_valid3 = '0; rsp_ready3 = '0; req_addr3 = {6'd3, 6'd2, 6'd1};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[r]) begin
            rst = tbl[r].rst; req_valid2 = tbl[r].rv; a0_2 = tbl[r].a0;
            rsp_ready2 = tbl[r].rdy_in;
            @(negedge clk);
            check($sformatf("c%0d req_ready", r), 32'(req_ready2), 32'(tbl[r].ready));
            check($sformatf("c%0d rom_addr", r), 32'(rom_addr2), 32'(tbl[r].rom));
            check($sformatf("c%0d rsp_valid", r), 32'(rsp_valid2), 32'(tbl[r].rspv));
            check($sformatf("c%0d busy", r), 32'(busy2), 32'(tbl[r].busy));
            if (tbl[r].rspv[0]) begin
                check($sformatf("c%0d c0[0]", r), 32'(rsp_c0_2[19:0]),
                      32'(20'h10000 + 20'(tbl[r].d0)));
                check($sformatf("c%0d c1[0]", r), 32'(rsp_c1_2[11:0]),
                      32'(12'h800 + 12'(tbl[r].d0)));
            end
            if (tbl[r].rspv[1]) begin
                check($sformatf("c%0d c0[1]", r), 32'(rsp_c0_2[39:20]),
                      32'(20'h10000 + 20'(tbl[r].d1)));
                check($sformatf("c%0d c1[1]", r), 32'(rsp_c1_2[23:12]),
                      32'(12'h800 + 12'(tbl[r].d1)));
            end
            @(posedge clk);
            #1;
        end

        // Mid-flight reset: accept ch1 addr 63, reset the next cycle.
        rst = 1'b0; req_valid2 = 2'b10; a1_2 = 6'd63; rsp_ready2 = 2'b11;
        @(negedge clk);
        check("mid accept", 32'(req_ready2), 32'h2);
        @(posedge clk); #1;
        rst = 1'b1; req_valid2 = 2'b00;
        @(negedge clk);
        check("mid rst rom_addr", 32'(rom_addr2), 32'd63);
        check("mid rst req_ready", 32'(req_ready2), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post rst rom_addr", 32'(rom_addr2), 32'h0);
        check("post rst busy", 32'(busy2), 32'h0);
        check("post rst rsp_c0", 32'(rsp_c0_2[39:20] | rsp_c0_2[19:0]), 32'h0);
        check("post rst rsp_c1", 32'(rsp_c1_2[23:12] | rsp_c1_2[11:0]), 32'h0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("post rst rsp_valid+%0d", k), 32'(rsp_valid2), 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid2 = 2'b10;
        @(negedge clk);
        check("retry accept", 32'(req_ready2), 32'h2);
        @(posedge clk); #1;
        req_valid2 = 2'b00;
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 8 && !found; k++) begin
            @(negedge clk);
            if (rsp_valid2[1]) begin
                found = 1'b1;
                lat = k;
            end
        end
        check("retry latency", 32'(lat), 32'd3);
        check("retry c0", 32'(rsp_c0_2[39:20]), 32'h1003F);
        check("retry c1", 32'(rsp_c1_2[23:12]), 32'h83F);

        // Wrap-around on 3 channels, all valid, all responses consumed.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid3 = 3'b111; rsp_ready3 = 3'b111;
        exp_next = 0;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_ready3 != 3'b000) begin
                check($sformatf("w%0d onehot", c), 32'($onehot(req_ready3)), 32'd1);
                gidx = req_ready3[0] ? 0 : (req_ready3[1] ? 1 : 2);
                check($sformatf("w%0d grant idx", c), 32'(gidx), 32'(exp_next));
                exp_next = (exp_next + 1) % 3;
                cnt[gidx]++;
            end
            for (int i = 0; i < 3; i++) begin
                if (rsp_valid3[i]) begin
                    check($sformatf("w%0d c0[%0d]", c, i), 32'(rsp_c0_3[i*20 +: 20]),
                          32'(20'h10001 + 20'(i)));
                end
            end
            @(posedge clk); #1;
        end
        check("wrap count ch0", 32'(cnt[0]), 32'd8);
        check("wrap count ch1", 32'(cnt[1]), 32'd8);
        check("wrap count ch2", 32'(cnt[2]), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sqrt_coeff_arbiter.md
Name: sqrt_coeff_arbiter

Overview:
- Shares the single sqrt-coefficient ROM of the AWGN generator between NUM_REQ Box-Muller requesters.
- The ROM takes a combinational 6-bit address and registers c0 (20 b) and c1 (12 b) one clock later.
- This block arbitrates address requests round-robin, drives the ROM address from a register, and tracks in-flight reads with per-channel tags.
- It returns each coefficient pair to its requester through a one-entry valid/ready response buffer per channel.

Parameters:
- NUM_REQ, 2: number of requesting channels (2..4).
- ADDR_W, 6: ROM address width.
- C0_W, 20: c0 coefficient width.
- C1_W, 12: c1 coefficient width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQ  per-channel request valid.
- req_ready  out  NUM_REQ  per-channel request accepted (grant), combinational.
- req_addr  in  NUM_REQ*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- rom_addr  out  ADDR_W  registered address to the coefficient ROM.
- rom_c0  in  C0_W  ROM c0 output, valid 1 cycle after rom_addr changes.
- rom_c1  in  C1_W  ROM c1 output, same timing as rom_c0.
- rsp_valid  out  NUM_REQ  per-channel response valid.
- rsp_ready  in  NUM_REQ  per-channel response consume.
- rsp_c0  out  NUM_REQ*C0_W  per-channel c0.
- rsp_c1  out  NUM_REQ*C1_W  per-channel c1.
- busy  out  1  any channel not IDLE, or any pipeline stage valid.

Behaviour:
- Channel state, per channel, 2 bits:
  - IDLE -> PEND on accept (req_valid[i] & req_ready[i]).
  - PEND -> FULL when its tagged ROM data is captured.
  - FULL -> IDLE on rsp_valid[i] & rsp_ready[i].
  - No other transitions. A channel is re-grantable only from the cycle after it returns to IDLE. At most one outstanding read per channel.
- Eligibility: req_valid[i] & state[i]==IDLE.
- Grant:
  - Round-robin from pointer rr.
  - Grant the first eligible index at or after rr, wrapping modulo NUM_REQ.
  - At most one grant per cycle.
  - req_ready is one-hot or zero.
  - On grant g, rr <= (g+1) mod NUM_REQ; otherwise rr holds.
- Pipeline:
  - Accept cycle N: rom_addr <= req_addr[g]; s1 <= {valid, g}.
  - Cycle N+1: s2 <= s1. The ROM registers data at the end of N+1.
  - Cycle N+2: if s2 valid, rsp_c0/rsp_c1[s2.id] <= rom_c0/rom_c1, and that channel goes to FULL.
  - rsp_valid[id] is high from cycle N+3 and holds with stable data until rsp_ready.
- rom_addr holds its last value when there is no grant.
- Throughput: one ROM read per cycle aggregate. Per channel, one every 4 cycles when rsp_ready is held high.
- rsp_valid[i] = (state[i]==FULL), registered-derived with no combinational path from rsp_ready.
- Simultaneous events:
  - A capture for channel j and a pop of channel k≠j in the same cycle are independent.
  - A capture and a grant in the same cycle to different channels are legal.
- Backpressure: rsp_ready low on a FULL channel only blocks that channel. Other channels continue to be granted.
- Reset (any cycle, including mid-flight):
  - rom_addr=0, rr=0, all states IDLE, s1/s2 valid=0, rsp_valid=0, rsp_c0=rsp_c1=0, busy=0, req_ready=0 during the reset cycle.
  - In-flight reads are discarded and no response is produced for them.
- Widths: no arithmetic on coefficients; pass-through bit-exact.

Decomposition:
- Shared package awgn_pkg:
  - ADDR_W/C0_W/C1_W constants.
  - Channel-state enum {IDLE, PEND, FULL}.
  - Tag typedef {vld, id[$clog2(NUM_REQ)]}.
- Sub-module rr_arbiter (eligible vector plus pointer -> one-hot grant plus index). Reused by the later multi-channel noise scheduler.

Test Plan:
- Bench ROM model: c0 = 20'h10000+addr, c1 = 12'h800+addr, 1-cycle registered.
- Single request: ch0 valid, addr 6'd5, rsp_ready=1, accepted cycle 0 -> rom_addr=5 in cycle 1; rsp_valid[0] in cycle 3 with c0=20'h10005, c1=12'h805; busy low from cycle 4.
- Contention: ch0 addr 3 and ch1 addr 40 both valid from reset, held valid -> grants ch0, ch1, then ch0 again only after its response is popped. Responses 20'h10003/12'h803 and 20'h10028/12'h828 land on the correct channels.
- Backpressure: ch1 rsp_ready=0 for 10 cycles after FULL -> rsp_valid[1] and data stable. ch1 is never re-granted; ch0 keeps completing every 4 cycles.
- Wrap-around, NUM_REQ=3, all valid continuously -> grant order 0,1,2,0,1,2. rr wraps from 2 to 0; no channel is starved over 30 cycles.
- Reset mid-flight: rst asserted in cycle N+1 after accepting ch1 addr 63 -> no rsp_valid ever for that read; all outputs 0 the following cycle. A new request after reset completes normally with c0=20'h1003F for addr 63.
